// File: rtl/tm1637_pkg.sv
// rtl/tm1637_pkg.sv - shared FSM state, command field constants and 7-segment codes
// for the TM1637 responder.
package tm1637_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_ACK,
    ST_WAIT_STOP
  } rx_state_t;

  localparam logic [1:0] CMD_NONE = 2'b00;
  localparam logic [1:0] CMD_DATA = 2'b01;
  localparam logic [1:0] CMD_CTRL = 2'b10;
  localparam logic [1:0] CMD_ADDR = 2'b11;
  localparam int DATA_FIXED_BIT = 2;
  localparam int DATA_KEY_BIT   = 1;
  localparam int CTRL_ON_BIT    = 3;

  localparam logic [7:0] SEG_0 = 8'h3F;
  localparam logic [7:0] SEG_1 = 8'h06;
  localparam logic [7:0] SEG_2 = 8'h5B;
  localparam logic [7:0] SEG_3 = 8'h4F;
  localparam logic [7:0] SEG_4 = 8'h66;
  localparam logic [7:0] SEG_5 = 8'h6D;
  localparam logic [7:0] SEG_6 = 8'h7D;
  localparam logic [7:0] SEG_7 = 8'h07;
  localparam logic [7:0] SEG_8 = 8'h7F;
  localparam logic [7:0] SEG_9 = 8'h6F;
  localparam logic [7:0] SEG_A = 8'h77;
  localparam logic [7:0] SEG_B = 8'h7C;
  localparam logic [7:0] SEG_C = 8'h39;
  localparam logic [7:0] SEG_D = 8'h5E;
  localparam logic [7:0] SEG_E = 8'h79;
  localparam logic [7:0] SEG_F = 8'h71;

  // Same hex-digit glyph table the initiator drives onto the bus.
  function automatic logic [7:0] seg_encode(input logic [3:0] nib);
    logic [7:0] s;
    s = SEG_0;
    case (nib)
      4'h0: s = SEG_0;
      4'h1: s = SEG_1;
      4'h2: s = SEG_2;
      4'h3: s = SEG_3;
      4'h4: s = SEG_4;
      4'h5: s = SEG_5;
      4'h6: s = SEG_6;
      4'h7: s = SEG_7;
      4'h8: s = SEG_8;
      4'h9: s = SEG_9;
      4'hA: s = SEG_A;
      4'hB: s = SEG_B;
      4'hC: s = SEG_C;
      4'hD: s = SEG_D;
      4'hE: s = SEG_E;
      default: s = SEG_F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/tm1637_line_sync.sv
// rtl/tm1637_line_sync.sv - pad synchroniser for one bus line; with
// TM1637_RX_GLITCH_FILTER_EN a 3-sample agreement filter follows it.
module tm1637_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic line_out
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], line_in};
    end
  end

`ifdef TM1637_RX_GLITCH_FILTER_EN
  logic [1:0] hist_q;
  logic       held_q;
  logic       agree;

  // New level passes only once it has been seen on three consecutive clocks.
  assign agree    = (sync_q[SYNC_STAGES-1] == hist_q[0]) && (hist_q[0] == hist_q[1]);
  assign line_out = agree ? sync_q[SYNC_STAGES-1] : held_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      hist_q <= 2'b11;
      held_q <= 1'b1;
    end else begin
      hist_q <= {hist_q[0], sync_q[SYNC_STAGES-1]};
      held_q <= line_out;
    end
  end
`else
  assign line_out = sync_q[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/tm1637_rx.sv
// rtl/tm1637_rx.sv - TM1637 bus responder: start/stop detect, LSB-first byte
// capture with ACK, command decode into digit registers. Option: TM1637_RX_GLITCH_FILTER_EN.
module tm1637_rx #(
  parameter int NUM_DIGITS  = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    scl_in,
  input  logic                    sda_in,
  output logic                    sda_en,
  output logic                    sda_out,
  output logic [8*NUM_DIGITS-1:0] seg_data,
  output logic                    disp_on,
  output logic [2:0]              brightness,
  output logic                    frame_done,
  output logic                    addr_err,
  output logic                    busy
);

  import tm1637_pkg::*;

  localparam logic [3:0] DIGITS_LIM = 4'(NUM_DIGITS);

  logic scl, sda, scl_prev, sda_prev;
  logic start_evt, stop_evt, scl_rise, scl_fall;

  tm1637_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .clk      (clk),
    .rst      (rst),
    .line_in  (scl_in),
    .line_out (scl)
  );

  tm1637_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .clk      (clk),
    .rst      (rst),
    .line_in  (sda_in),
    .line_out (sda)
  );

  assign start_evt = scl && scl_prev && sda_prev && !sda;
  assign stop_evt  = scl && scl_prev && !sda_prev && sda;
  assign scl_rise  = scl && !scl_prev;
  assign scl_fall  = !scl && scl_prev;

  rx_state_t  state;
  logic [7:0] shreg;
  logic [3:0] bit_cnt;
  logic       is_cmd;
  logic       ack_high;
  logic [2:0] addr;
  logic       fixed_mode;
  logic       got_byte;
  logic [7:0] digit_q [NUM_DIGITS];

  assign sda_out = 1'b0;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_seg
    assign seg_data[8*g +: 8] = digit_q[g];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_prev <= scl;
      sda_prev <= sda;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      is_cmd     <= 1'b0;
      ack_high   <= 1'b0;
      addr       <= '0;
      fixed_mode <= 1'b0;
      got_byte   <= 1'b0;
      sda_en     <= 1'b0;
      disp_on    <= 1'b0;
      brightness <= '0;
      frame_done <= 1'b0;
      addr_err   <= 1'b0;
      busy       <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= '0;
    end else begin
      frame_done <= 1'b0;
      if (stop_evt) begin
        state      <= ST_IDLE;
        sda_en     <= 1'b0;
        busy       <= 1'b0;
        frame_done <= got_byte;
        got_byte   <= 1'b0;
      end else if (start_evt) begin
        // Repeated start lands here too and throws away any partial byte.
        state   <= ST_CMD;
        bit_cnt <= '0;
        sda_en  <= 1'b0;
        busy    <= 1'b1;
      end else begin
        case (state)
          ST_CMD, ST_DATA: begin
            if (scl_rise && bit_cnt != 4'd8) begin
              shreg   <= {sda, shreg[7:1]};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= '0;
              if (state == ST_CMD && shreg[7:6] == CMD_NONE) begin
                state <= ST_WAIT_STOP;
              end else begin
                sda_en   <= 1'b1;
                ack_high <= 1'b0;
                is_cmd   <= (state == ST_CMD);
                state    <= ST_ACK;
              end
            end
          end
          ST_ACK: begin
            if (scl_rise) begin
              ack_high <= 1'b1;
            end else if (scl_fall && ack_high) begin
              sda_en   <= 1'b0;
              got_byte <= 1'b1;
              if (is_cmd) begin
                state <= ST_WAIT_STOP;
                case (shreg[7:6])
                  CMD_DATA: fixed_mode <= shreg[DATA_FIXED_BIT];
                  CMD_ADDR: begin
                    addr     <= shreg[2:0];
                    addr_err <= 1'b0;
                    state    <= ST_DATA;
                  end
                  CMD_CTRL: begin
                    disp_on    <= shreg[CTRL_ON_BIT];
                    brightness <= shreg[2:0];
                  end
                  default: ;
                endcase
              end else begin
                state <= ST_DATA;
                if ({1'b0, addr} < DIGITS_LIM) begin
                  for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (addr == i[2:0]) digit_q[i] <= shreg;
                  end
                end else begin
                  addr_err <= 1'b1;
                end
                if (!fixed_mode) addr <= addr + 3'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tm1637_rx.sv
// tb/tb_tm1637_rx.sv - bus-level bench for tm1637_rx: a bit-banged initiator,
// transaction model and frame scoreboard popped on each frame_done.
module tb_tm1637_rx;

  localparam int ND = 6;
  localparam int SS = 2;
  localparam int H  = 8;
`ifdef TM1637_RX_GLITCH_FILTER_EN
  localparam int LAT = SS + 3;
`else
  localparam int LAT = SS + 1;
`endif

  typedef struct packed {
    logic [8*ND-1:0] seg;
    logic            disp;
    logic [2:0]      bri;
    logic            err;
  } snap_t;

  logic clk = 1'b0;
  logic rst;
  logic scl_m, sda_m;
  logic scl_in, sda_in;
  logic sda_en, sda_out;
  logic [8*ND-1:0] seg_data;
  logic disp_on;
  logic [2:0] brightness;
  logic frame_done, addr_err, busy;

  int vectors = 0;
  int miscompares = 0;
  int frame_cnt = 0;
  snap_t exp_q[$];
  snap_t mon_s;
  logic [7:0] tx_q[$];

  logic [7:0] m_seg [ND];
  logic       m_fixed;
  logic [2:0] m_addr;
  logic       m_disp;
  logic [2:0] m_bri;
  logic       m_err;

  always #5 clk = ~clk;

  // Open-drain bus: the responder can only pull SDA low.
  assign scl_in = scl_m;
  assign sda_in = sda_m & ~(sda_en & ~sda_out);

  tm1637_rx #(.NUM_DIGITS(ND), .SYNC_STAGES(SS)) dut (
    .clk        (clk),
    .rst        (rst),
    .scl_in     (scl_in),
    .sda_in     (sda_in),
    .sda_en     (sda_en),
    .sda_out    (sda_out),
    .seg_data   (seg_data),
    .disp_on    (disp_on),
    .brightness (brightness),
    .frame_done (frame_done),
    .addr_err   (addr_err),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [8*ND-1:0] m_flat();
    logic [8*ND-1:0] f;
    for (int i = 0; i < ND; i++) f[8*i +: 8] = m_seg[i];
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ND; i++) m_seg[i] = 8'h00;
    m_fixed = 1'b0; m_addr = 3'd0; m_disp = 1'b0; m_bri = 3'd0; m_err = 1'b0;
  endtask

  task automatic model_cmd(input logic [7:0] b);
    case (b[7:6])
      2'b01: m_fixed = b[2];
      2'b11: begin m_addr = b[2:0]; m_err = 1'b0; end
      2'b10: begin m_disp = b[3]; m_bri = b[2:0]; end
      default: ;
    endcase
  endtask

  task automatic model_data(input logic [7:0] b);
    if (int'(m_addr) < ND) m_seg[m_addr] = b;
    else m_err = 1'b1;
    if (!m_fixed) m_addr = m_addr + 3'd1;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b0; wait_clk(H);
    check("busy_start", busy, 1'b1);
    scl_m = 1'b0; wait_clk(H);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_clk(H);
    scl_m = 1'b1; wait_clk(H);
    sda_m = 1'b1; wait_clk(H);
    check("busy_stop", busy, 1'b0);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      sda_m = b[i]; wait_clk(H);
      scl_m = 1'b1; wait_clk(H);
      scl_m = 1'b0;
    end
  endtask

  // Eight data clocks, then the ninth (ACK) clock with timing checks on sda_en.
  task automatic send_byte(input logic [7:0] b, input logic exp_ack);
    send_bits(b, 8);
    repeat (LAT) @(posedge clk);
    #1 check("ack_rise", sda_en, exp_ack);
    @(negedge clk);
    sda_m = 1'b1; wait_clk(H);
    scl_m = 1'b1; wait_clk(H);
    check("ack_hold", sda_en, exp_ack);
    check("sda_out", sda_out, 1'b0);
    scl_m = 1'b0;
    repeat (LAT) @(posedge clk);
    #1 check("ack_fall", sda_en, 1'b0);
    @(negedge clk);
    wait_clk(H);
  endtask

  task automatic send_frame();
    logic got;
    logic [7:0] b;
    snap_t s;
    got = 1'b0;
    bus_start();
    for (int i = 0; i < tx_q.size(); i++) begin
      b = tx_q[i];
      if (i == 0 && b[7:6] == 2'b00) begin
        send_byte(b, 1'b0);
        break;
      end
      send_byte(b, 1'b1);
      if (i == 0) model_cmd(b);
      else model_data(b);
      got = 1'b1;
    end
    if (got) begin
      s.seg = m_flat(); s.disp = m_disp; s.bri = m_bri; s.err = m_err;
      exp_q.push_back(s);
    end
    bus_stop();
    tx_q.delete();
  endtask

  always @(negedge clk) begin
    if (rst && frame_done) begin
      frame_cnt++;
      if (exp_q.size() == 0) begin
        check("frame_unexpected", 1'b1, 1'b0);
      end else begin
        mon_s = exp_q.pop_front();
        check("frame_seg", seg_data, mon_s.seg);
        check("frame_disp", disp_on, mon_s.disp);
        check("frame_bri", brightness, mon_s.bri);
        check("frame_err", addr_err, mon_s.err);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int f0;
    rst = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
    model_reset();
    wait_clk(4);
    check("rst_seg", seg_data, '0);
    check("rst_sda_en", sda_en, 1'b0);
    check("rst_disp", disp_on, 1'b0);
    check("rst_bri", brightness, 3'd0);
    check("rst_frame", frame_done, 1'b0);
    check("rst_err", addr_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b1;
    wait_clk(4);

    // "bEEF" into digits 0..3, then display on at full brightness.
    f0 = frame_cnt;
    tx_q = '{8'h40}; send_frame();
    tx_q = '{8'hC0, 8'h7C, 8'h79, 8'h79, 8'h71}; send_frame();
    tx_q = '{8'h8F}; send_frame();
    wait_clk(4);
    check("beef_frames", frame_cnt - f0, 3);
    check("beef_d0", seg_data[7:0], 8'h7C);
    check("beef_d1", seg_data[15:8], 8'h79);
    check("beef_d2", seg_data[23:16], 8'h79);
    check("beef_d3", seg_data[31:24], 8'h71);
    check("beef_on", disp_on, 1'b1);
    check("beef_bri", brightness, 3'd7);

    // Fixed addressing: both bytes land on digit 2.
    tx_q = '{8'h44}; send_frame();
    tx_q = '{8'hC2, 8'h3F, 8'h06}; send_frame();
    wait_clk(4);
    check("fixed_d2", seg_data[23:16], 8'h06);
    check("fixed_d1", seg_data[15:8], 8'h79);
    check("fixed_d3", seg_data[31:24], 8'h71);
    check("fixed_err", addr_err, 1'b0);

    // Auto increment past the last digit.
    tx_q = '{8'h40}; send_frame();
    tx_q = '{8'hC4, 8'h11, 8'h22, 8'h33}; send_frame();
    wait_clk(4);
    check("ovf_d4", seg_data[39:32], 8'h11);
    check("ovf_d5", seg_data[47:40], 8'h22);
    check("ovf_d0", seg_data[7:0], 8'h7C);
    check("ovf_err", addr_err, 1'b1);
    tx_q = '{8'hC0}; send_frame();
    wait_clk(4);
    check("ovf_clear", addr_err, 1'b0);

    // Invalid command: no ACK, no change, no frame_done.
    f0 = frame_cnt;
    tx_q = '{8'h00}; send_frame();
    wait_clk(4);
    check("inv_frames", frame_cnt - f0, 0);
    check("inv_seg", seg_data, m_flat());

    // Repeated start after a partial byte.
    bus_start();
    send_bits(8'hFF, 4);
    sda_m = 1'b1; wait_clk(H);
    scl_m = 1'b1; wait_clk(H);
    sda_m = 1'b0; wait_clk(H);
    check("rs_busy", busy, 1'b1);
    scl_m = 1'b0; wait_clk(H);
    send_byte(8'h8A, 1'b1);
    model_cmd(8'h8A);
    mon_s.seg = m_flat(); mon_s.disp = m_disp; mon_s.bri = m_bri; mon_s.err = m_err;
    exp_q.push_back(mon_s);
    bus_stop();
    wait_clk(4);
    check("rs_on", disp_on, 1'b1);
    check("rs_bri", brightness, 3'd2);
    check("rs_seg", seg_data, m_flat());

    // Reset in the middle of a data byte.
    bus_start();
    send_byte(8'hC0, 1'b1);
    model_cmd(8'hC0);
    send_bits(8'h55, 4);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("abort_seg", seg_data, '0);
    check("abort_disp", disp_on, 1'b0);
    check("abort_bri", brightness, 3'd0);
    check("abort_busy", busy, 1'b0);
    check("abort_sda_en", sda_en, 1'b0);
    check("abort_err", addr_err, 1'b0);
    @(negedge clk);
    scl_m = 1'b1; sda_m = 1'b1;
    model_reset();
    wait_clk(4);
    rst = 1'b1;
    wait_clk(4);
    tx_q = '{8'hC0, 8'h3F}; send_frame();
    wait_clk(4);
    check("post_rst_d0", seg_data[7:0], 8'h3F);

`ifdef TM1637_RX_GLITCH_FILTER_EN
    sda_m = 1'b0;
    @(negedge clk) sda_m = 1'b1;
    wait_clk(10);
    check("glitch_busy", busy, 1'b0);
`endif

    wait_clk(10);
    check("frames_pending", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
